// File: rtl/sprite_bounce_pkg.sv
// Shared state encoding, direction constants and default field size for the
// bouncing-sprite engine.
package sprite_bounce_pkg;

  typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, MOVE} state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int unsigned DEF_SCR_W = 160;
  localparam int unsigned DEF_SCR_H = 120;

endpackage

// File: rtl/sprite_bounce_engine_frame_tick_gen.sv
// Frame-rate divider: TICK_DIV clocks per frame tick, FRAMES ticks per step.
// step_due pulses for one cycle on the last clock of the last frame.
module frame_tick_gen #(
  parameter int unsigned TICK_DIV = 833334,
  parameter int unsigned FRAMES   = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic step_due
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  logic [TW-1:0] r_tick;
  logic [FW-1:0] r_frame;
  logic          w_tick_wrap;

  assign w_tick_wrap = en && (r_tick == TICK_LAST);
  assign step_due    = w_tick_wrap && (r_frame == FRAME_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick  <= '0;
      r_frame <= '0;
    end else if (clr) begin
      r_tick  <= '0;
      r_frame <= '0;
    end else if (en) begin
      if (w_tick_wrap) begin
        r_tick  <= '0;
        r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + FW'(1);
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite animator: erase, move, redraw one pixel per clk into the VGA adapter.
// Optional `SPRITE_BOUNCE_CNT_EN adds a saturating 16-bit reflection counter output.
module sprite_bounce_engine
  import sprite_bounce_pkg::*;
#(
  parameter int unsigned SCR_W    = DEF_SCR_W,
  parameter int unsigned SCR_H    = DEF_SCR_H,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned SPR_W    = 4,
  parameter int unsigned SPR_H    = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned TICK_DIV = 833334,
  parameter int unsigned FRAMES   = 15,
  parameter int unsigned COL_W    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic             ld_colour,
  input  logic [COL_W-1:0] colour_in,
  output logic [XW-1:0]    x_out,
  output logic [YW-1:0]    y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             bounce_x,
  output logic             bounce_y
`ifdef SPRITE_BOUNCE_CNT_EN
  ,
  output logic [15:0]      bounce_cnt
`endif
);

  localparam logic [XW:0]   XMAX    = (XW+1)'(SCR_W - SPR_W);
  localparam logic [YW:0]   YMAX    = (YW+1)'(SCR_H - SPR_H);
  localparam logic [XW:0]   XSTEP   = (XW+1)'(STEP);
  localparam logic [YW:0]   YSTEP   = (YW+1)'(STEP);
  localparam logic [XW-1:0] LAST_DX = XW'(SPR_W - 1);
  localparam logic [YW-1:0] LAST_DY = YW'(SPR_H - 1);
  localparam logic [YW-1:0] Y_INIT  = YW'(SCR_H / 2);

  state_t           r_state;
  logic [XW-1:0]    r_pos_x, r_dx, r_x;
  logic [YW-1:0]    r_pos_y, r_dy, r_y;
  logic             r_dir_x, r_dir_y;
  logic [COL_W-1:0] r_colour, r_col;
  logic             r_plot, r_bx, r_by;

  logic [XW:0]      w_sum_x;
  logic [YW:0]      w_sum_y;
  logic [XW-1:0]    w_nx, w_base_x, w_dx_inc;
  logic [YW-1:0]    w_ny, w_base_y, w_dy_inc;
  logic             w_ndir_x, w_ndir_y, w_bx, w_by;
  logic             w_start, w_last, w_row_end, w_step_due, w_tick_en;
  logic [COL_W-1:0] w_start_col;

  assign w_tick_en = (r_state == WAIT);

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .FRAMES  (FRAMES)
  ) u_tick (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (!w_tick_en),
    .en      (w_tick_en),
    .step_due(w_step_due)
  );

  // Reflection is computed one bit wider than the coordinate so pos+STEP never wraps.
  always_comb begin
    w_sum_x  = {1'b0, r_pos_x} + XSTEP;
    w_nx     = w_sum_x[XW-1:0];
    w_ndir_x = r_dir_x;
    w_bx     = 1'b0;
    if (r_dir_x == DIR_POS) begin
      if (w_sum_x > XMAX) begin
        w_nx = XMAX[XW-1:0]; w_ndir_x = DIR_NEG; w_bx = 1'b1;
      end
    end else if ({1'b0, r_pos_x} < XSTEP) begin
      w_nx = '0; w_ndir_x = DIR_POS; w_bx = 1'b1;
    end else begin
      w_nx = r_pos_x - XSTEP[XW-1:0];
    end
  end

  always_comb begin
    w_sum_y  = {1'b0, r_pos_y} + YSTEP;
    w_ny     = w_sum_y[YW-1:0];
    w_ndir_y = r_dir_y;
    w_by     = 1'b0;
    if (r_dir_y == DIR_POS) begin
      if (w_sum_y > YMAX) begin
        w_ny = YMAX[YW-1:0]; w_ndir_y = DIR_NEG; w_by = 1'b1;
      end
    end else if ({1'b0, r_pos_y} < YSTEP) begin
      w_ny = '0; w_ndir_y = DIR_POS; w_by = 1'b1;
    end else begin
      w_ny = r_pos_y - YSTEP[YW-1:0];
    end
  end

  assign w_row_end = (r_dx == LAST_DX);
  assign w_last    = w_row_end && (r_dy == LAST_DY);
  assign w_dx_inc  = r_dx + XW'(1);
  assign w_dy_inc  = r_dy + YW'(1);

  // Scan start: the first pixel is registered on the same edge that enters DRAW/ERASE.
  always_comb begin
    w_start     = 1'b0;
    w_base_x    = r_pos_x;
    w_base_y    = r_pos_y;
    w_start_col = r_colour;
    case (r_state)
      IDLE: w_start = run;
      WAIT: begin w_start = run && w_step_due; w_start_col = '0; end
      MOVE: begin w_start = 1'b1; w_base_x = w_nx; w_base_y = w_ny; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_pos_x  <= '0;
      r_pos_y  <= Y_INIT;
      r_dir_x  <= DIR_POS;
      r_dir_y  <= DIR_POS;
      r_colour <= '1;
      r_dx     <= '0;
      r_dy     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_col    <= '0;
      r_plot   <= 1'b0;
      r_bx     <= 1'b0;
      r_by     <= 1'b0;
    end else begin
      r_bx <= 1'b0;
      r_by <= 1'b0;
      if (ld_colour) r_colour <= colour_in;
      case (r_state)
        IDLE:  if (run) r_state <= DRAW;
        DRAW:  if (w_last) r_state <= WAIT;
        WAIT:  if (!run) r_state <= IDLE; else if (w_step_due) r_state <= ERASE;
        ERASE: if (w_last) r_state <= MOVE;
        MOVE: begin
          r_state <= DRAW;
          r_pos_x <= w_nx;
          r_pos_y <= w_ny;
          r_dir_x <= w_ndir_x;
          r_dir_y <= w_ndir_y;
          r_bx    <= w_bx;
          r_by    <= w_by;
        end
        default: r_state <= IDLE;
      endcase
      if (w_start) begin
        r_plot <= 1'b1;
        r_dx   <= '0;
        r_dy   <= '0;
        r_x    <= w_base_x;
        r_y    <= w_base_y;
        r_col  <= w_start_col;
      end else if (r_plot) begin
        if (w_last) begin
          r_plot <= 1'b0;
        end else if (w_row_end) begin
          r_dx <= '0;
          r_dy <= w_dy_inc;
          r_x  <= r_pos_x;
          r_y  <= r_pos_y + w_dy_inc;
        end else begin
          r_dx <= w_dx_inc;
          r_x  <= r_pos_x + w_dx_inc;
        end
      end
    end
  end

`ifdef SPRITE_BOUNCE_CNT_EN
  logic [15:0] r_bcnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_bcnt <= '0;
    else if ((r_state == MOVE) && (w_bx || w_by) && (r_bcnt != '1))
      r_bcnt <= r_bcnt + 16'd1;
  end
  assign bounce_cnt = r_bcnt;
`endif

  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_col;
  assign plot       = r_plot;
  assign busy       = r_state inside {DRAW, ERASE, MOVE};
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign bounce_x   = r_bx;
  assign bounce_y   = r_by;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Bench for sprite_bounce_engine: pixel scoreboard on a 160x120 instance plus a
// movement table on a small STEP=3 field that exercises clamping and corners.
module tb_sprite_bounce_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: 160x120, 4x4 sprite, STEP 1, WAIT = 2*2 cycles
  logic       a_rstn, a_run, a_ld;
  logic [2:0] a_cin, a_col;
  logic [7:0] a_x, a_px;
  logic [6:0] a_y, a_py;
  logic       a_plot, a_busy, a_bx, a_by;
  // Instance B: 10x16 field, 3x2 sprite, STEP 3, WAIT = 1 cycle
  logic       b_rstn, b_run, b_ld;
  logic [2:0] b_cin, b_col;
  logic [3:0] b_x, b_px, b_y, b_py;
  logic       b_plot, b_busy, b_bx, b_by;
`ifdef SPRITE_BOUNCE_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  sprite_bounce_engine #(
    .SCR_W(160), .SCR_H(120), .XW(8), .YW(7), .SPR_W(4), .SPR_H(4),
    .STEP(1), .TICK_DIV(2), .FRAMES(2), .COL_W(3)
  ) u_a (
    .clk(clk), .resetn(a_rstn), .run(a_run), .ld_colour(a_ld), .colour_in(a_cin),
    .x_out(a_x), .y_out(a_y), .colour_out(a_col), .plot(a_plot), .busy(a_busy),
    .pos_x(a_px), .pos_y(a_py), .bounce_x(a_bx), .bounce_y(a_by)
`ifdef SPRITE_BOUNCE_CNT_EN
    , .bounce_cnt(a_cnt)
`endif
  );

  sprite_bounce_engine #(
    .SCR_W(10), .SCR_H(16), .XW(4), .YW(4), .SPR_W(3), .SPR_H(2),
    .STEP(3), .TICK_DIV(1), .FRAMES(1), .COL_W(3)
  ) u_b (
    .clk(clk), .resetn(b_rstn), .run(b_run), .ld_colour(b_ld), .colour_in(b_cin),
    .x_out(b_x), .y_out(b_y), .colour_out(b_col), .plot(b_plot), .busy(b_busy),
    .pos_x(b_px), .pos_y(b_py), .bounce_x(b_bx), .bounce_y(b_by)
`ifdef SPRITE_BOUNCE_CNT_EN
    , .bounce_cnt(b_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;
  pix_t sb[$];

  typedef struct {
    int x;
    int y;
    int bx;
    int by;
    int cnt;
  } mv_t;
  mv_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_burst(input int x0, input int y0, input int c);
    pix_t p;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        p.x = 8'(x0 + dx);
        p.y = 7'(y0 + dy);
        p.c = 3'(c);
        sb.push_back(p);
      end
  endtask

  // Waits on negedges until A's plot equals lvl; n = negedges consumed.
  task automatic wait_plot(input logic lvl, input int max, output int n);
    n = 0;
    while (a_plot !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (a_plot !== lvl) begin
      n_total++;
      $display("FAIL timeout_plot: plot stayed %0b for %0d cycles, wanted %0b", a_plot, max, lvl);
    end
  endtask

  // Waits for the first pixel of a DRAW burst on B (plot rising with non-zero colour).
  task automatic wait_b_draw(input int idx);
    logic prev;
    bit   hit;
    prev = b_plot;
    hit  = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (b_plot && !prev && b_col != 3'd0) hit = 1'b1;
      prev = b_plot;
    end
    if (!hit) begin
      n_total++;
      $display("FAIL b_draw_timeout: move %0d never started a DRAW", idx);
    end
  endtask

  always @(negedge clk) begin
    if (a_plot) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: plot at (%0d,%0d) col %0d with nothing expected", a_x, a_y, a_col);
      end else begin
        pix_t e;
        e = sb.pop_front();
        check("pixel", {14'd0, a_x, a_y, a_col}, {14'd0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{0, 8, 0, 0, 0};
    tbl[1] = '{3, 11, 0, 0, 0};
    tbl[2] = '{6, 14, 0, 0, 0};
    tbl[3] = '{7, 14, 1, 1, 1};
    tbl[4] = '{4, 11, 0, 0, 1};
    tbl[5] = '{1, 8, 0, 0, 1};
    tbl[6] = '{0, 5, 1, 0, 2};
    tbl[7] = '{3, 2, 0, 0, 2};
    tbl[8] = '{6, 0, 0, 1, 3};

    a_rstn = 1'b0; a_run = 1'b0; a_ld = 1'b0; a_cin = '0;
    b_rstn = 1'b0; b_run = 1'b0; b_ld = 1'b0; b_cin = '0;
    repeat (3) @(negedge clk);

    check("rst_flags", {28'd0, a_plot, a_busy, a_bx, a_by}, 32'd0);
    check("rst_xyc", {14'd0, a_x, a_y, a_col}, 32'd0);
    check("rst_pos", {17'd0, a_px, a_py}, {17'd0, 8'd0, 7'd60});
`ifdef SPRITE_BOUNCE_CNT_EN
    check("rst_cnt", {16'd0, a_cnt}, 32'd0);
`endif

    a_rstn = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (a_plot) n++; end
    check("idle_no_plot", n, 0);
    check("idle_pos", {17'd0, a_px, a_py}, {17'd0, 8'd0, 7'd60});

    // First step: draw, wait, erase, move, redraw one pixel down-right.
    push_burst(0, 60, 7);
    push_burst(0, 60, 0);
    push_burst(1, 61, 7);
    a_run = 1'b1;
    @(negedge clk);
    check("first_plot_latency", a_plot, 1);
    check("draw_busy", a_busy, 1);
    wait_plot(1'b0, 40, n); check("draw_len", n, 16);
    wait_plot(1'b1, 40, n); check("wait_len", n, 4);
    wait_plot(1'b0, 40, n); check("erase_len", n, 16);
    wait_plot(1'b1, 40, n); check("move_gap", n, 1);
    check("moved_pos", {17'd0, a_px, a_py}, {17'd0, 8'd1, 7'd61});
    check("no_bounce", {a_bx, a_by}, 0);

    // Colour load mid-burst must not affect this burst; run drop after the 7th pixel.
    repeat (2) @(negedge clk);
    a_cin = 3'd2; a_ld = 1'b1;
    @(negedge clk);
    a_ld = 1'b0;
    repeat (3) @(negedge clk);
    a_run = 1'b0;
    n = 0;
    repeat (12) begin @(negedge clk); if (a_plot) n++; end
    check("plots_after_run_low", n, 9);
    n = 0;
    repeat (20) begin @(negedge clk); if (a_plot) n++; end
    check("parked_no_plot", n, 0);
    check("parked_busy", a_busy, 0);
    check("parked_pos", {17'd0, a_px, a_py}, {17'd0, 8'd1, 7'd61});
    check("sb_drained", sb.size(), 0);

    // Restart uses the loaded colour, then reset lands in the middle of ERASE.
    push_burst(1, 61, 2);
    push_burst(1, 61, 0);
    a_run = 1'b1;
    wait_plot(1'b1, 5, n); check("restart_latency", n, 1);
    wait_plot(1'b0, 40, n);
    wait_plot(1'b1, 40, n);
    check("erase_colour", a_col, 0);
    repeat (4) @(negedge clk);
    #2 a_rstn = 1'b0;
    #1;
    check("rst_mid_erase_plot", a_plot, 0);
    check("rst_mid_erase_busy", a_busy, 0);
    check("rst_mid_erase_pos", {17'd0, a_px, a_py}, {17'd0, 8'd0, 7'd60});
    sb.delete();
    @(negedge clk);
    a_rstn = 1'b1;
    a_run  = 1'b0;
    repeat (2) @(negedge clk);

    // Colour register back to all-ones after reset.
    push_burst(0, 60, 7);
    a_run = 1'b1;
    wait_plot(1'b1, 5, n);
    a_run = 1'b0;
    wait_plot(1'b0, 40, n);
    repeat (8) @(negedge clk);
    check("sb_drained2", sb.size(), 0);
    check("idle_after_reset_burst", a_busy, 0);

    // Instance B: movement table including a clamped corner and floor clamps.
    b_rstn = 1'b1;
    b_run  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_b_draw(i);
      check($sformatf("b_move%0d_x", i), b_px, tbl[i].x);
      check($sformatf("b_move%0d_y", i), b_py, tbl[i].y);
      check($sformatf("b_move%0d_bounce", i), {b_bx, b_by}, 2 * tbl[i].bx + tbl[i].by);
`ifdef SPRITE_BOUNCE_CNT_EN
      check($sformatf("b_move%0d_cnt", i), b_cnt, tbl[i].cnt);
`endif
      @(negedge clk);
      check($sformatf("b_move%0d_pulse_end", i), {b_bx, b_by}, 0);
    end
    b_run = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
